// File: rtl/clause_vote_engine.sv
// rtl/clause_vote_engine.sv - streaming Tsetlin clause evaluation, per-class vote sums and argmax
// Optional SUM_SATURATE_EN: clamp the vote accumulator symmetrically instead of wrapping.
module clause_vote_engine #(
    parameter int FEATURES  = 8,
    parameter int CLASS_LEN = 4,
    parameter int SUM_W     = 10
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_compute,
    input  logic [FEATURES-1:0]         input_literals,
    input  logic                        clause_valid,
    output logic                        clause_ready,
    input  logic [CLASS_LEN-1:0]        clause_class,
    input  logic                        clause_polarity,
    input  logic [2*FEATURES-1:0]       clause_include,
    input  logic                        clause_last,
    output logic                        clause_fire,
    output logic                        sum_valid,
    output logic [CLASS_LEN-1:0]        sum_class,
    output logic signed [SUM_W-1:0]     sum_value,
    output logic                        result_valid,
    output logic [CLASS_LEN-1:0]        predicted_class,
    output logic signed [SUM_W-1:0]     predicted_sum,
    output logic                        busy
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic signed [SUM_W-1:0] ONE      = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] MOST_NEG = {1'b1, {(SUM_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {1'b0, {(SUM_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {1'b1, {(SUM_W-2){1'b0}}, 1'b1};

    state_t                   state, state_next;
    logic [FEATURES-1:0]      x_reg;
    logic [2*FEATURES-1:0]    lit;
    logic signed [SUM_W-1:0]  acc, acc_next, vote, best_sum;
    logic [CLASS_LEN-1:0]     cur_class, best_class;
    logic                     first, fire, accept, same_group;

    assign clause_ready = (state == S_RUN);
    assign busy         = (state != S_IDLE);
    assign accept       = clause_valid & clause_ready;
    assign lit          = {~x_reg, x_reg};
    assign fire         = (|clause_include) && ((clause_include & ~lit) == '0);
    assign vote         = fire ? (clause_polarity ? ONE : -ONE) : '0;
    assign same_group   = first || (clause_class == cur_class);

    always_comb begin
        acc_next = acc + vote;
`ifdef SUM_SATURATE_EN
        if ((vote == ONE && acc == SAT_MAX) || (vote == -ONE && acc == SAT_MIN))
            acc_next = acc;
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_compute) state_next = S_RUN;
            S_RUN:   if (accept && clause_last) state_next = S_FLUSH;
            S_FLUSH: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg           <= '0;
            acc             <= '0;
            cur_class       <= '0;
            first           <= 1'b0;
            best_sum        <= '0;
            best_class      <= '0;
            clause_fire     <= 1'b0;
            sum_valid       <= 1'b0;
            sum_class       <= '0;
            sum_value       <= '0;
            result_valid    <= 1'b0;
            predicted_class <= '0;
            predicted_sum   <= '0;
        end else begin
            sum_valid    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: if (start_compute) begin
                    x_reg       <= input_literals;
                    acc         <= '0;
                    best_sum    <= MOST_NEG;
                    best_class  <= '0;
                    first       <= 1'b1;
                    clause_fire <= 1'b0;
                end
                S_RUN: if (accept) begin
                    clause_fire <= fire;
                    first       <= 1'b0;
                    cur_class   <= clause_class;
                    if (same_group) begin
                        acc <= acc_next;
                    end else begin
                        // Class boundary: emit the closed group and rank it before restarting acc.
                        sum_valid <= 1'b1;
                        sum_class <= cur_class;
                        sum_value <= acc;
                        if (acc > best_sum) begin
                            best_sum   <= acc;
                            best_class <= cur_class;
                        end
                        acc <= vote;
                    end
                end
                S_FLUSH: begin
                    sum_valid    <= 1'b1;
                    sum_class    <= cur_class;
                    sum_value    <= acc;
                    result_valid <= 1'b1;
                    if (acc > best_sum) begin
                        best_sum        <= acc;
                        best_class      <= cur_class;
                        predicted_class <= cur_class;
                        predicted_sum   <= acc;
                    end else begin
                        predicted_class <= best_class;
                        predicted_sum   <= best_sum;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_clause_vote_engine.sv
// tb/tb_clause_vote_engine.sv - directed self-checking bench for clause_vote_engine
module tb_clause_vote_engine;
    logic        clock = 1'b0;
    logic        reset;
    logic        start_compute;
    logic [7:0]  input_literals;
    logic        clause_valid;
    logic [3:0]  clause_class;
    logic        clause_polarity;
    logic [15:0] clause_include;
    logic        clause_last;

    logic        clause_ready, clause_fire, sum_valid, result_valid, busy;
    logic [3:0]  sum_class, predicted_class;
    logic [9:0]  sum_value, predicted_sum;

    logic        s4_clause_ready, s4_clause_fire, s4_sum_valid, s4_result_valid, s4_busy;
    logic [3:0]  s4_sum_class, s4_predicted_class;
    logic [3:0]  s4_sum_value, s4_predicted_sum;

    int checks = 0;
    int errors = 0;
    logic [3:0] qc[$];
    logic [9:0] qv[$];
    int res_cnt = 0;
    int base, base_r;
    logic f;

    always #5 clock = ~clock;

    clause_vote_engine #(.FEATURES(8), .CLASS_LEN(4), .SUM_W(10)) dut (
        .clock(clock), .reset(reset), .start_compute(start_compute),
        .input_literals(input_literals), .clause_valid(clause_valid),
        .clause_ready(clause_ready), .clause_class(clause_class),
        .clause_polarity(clause_polarity), .clause_include(clause_include),
        .clause_last(clause_last), .clause_fire(clause_fire),
        .sum_valid(sum_valid), .sum_class(sum_class), .sum_value(sum_value),
        .result_valid(result_valid), .predicted_class(predicted_class),
        .predicted_sum(predicted_sum), .busy(busy)
    );

    clause_vote_engine #(.FEATURES(8), .CLASS_LEN(4), .SUM_W(4)) dut4 (
        .clock(clock), .reset(reset), .start_compute(start_compute),
        .input_literals(input_literals), .clause_valid(clause_valid),
        .clause_ready(s4_clause_ready), .clause_class(clause_class),
        .clause_polarity(clause_polarity), .clause_include(clause_include),
        .clause_last(clause_last), .clause_fire(s4_clause_fire),
        .sum_valid(s4_sum_valid), .sum_class(s4_sum_class), .sum_value(s4_sum_value),
        .result_valid(s4_result_valid), .predicted_class(s4_predicted_class),
        .predicted_sum(s4_predicted_sum), .busy(s4_busy)
    );

    always @(negedge clock) begin
        if (sum_valid) begin
            qc.push_back(sum_class);
            qv.push_back(sum_value);
        end
        if (result_valid) res_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] x);
        start_compute  = 1'b1;
        input_literals = x;
        @(negedge clock);
        start_compute  = 1'b0;
    endtask

    task automatic send(input logic [3:0] c, input logic p, input logic [15:0] inc,
                        input logic l, output logic fo);
        clause_class    = c;
        clause_polarity = p;
        clause_include  = inc;
        clause_last     = l;
        clause_valid    = 1'b1;
        @(posedge clock);
        @(negedge clock);
        clause_valid = 1'b0;
        clause_last  = 1'b0;
        fo = clause_fire;
    endtask

    initial begin
        reset = 1'b0; start_compute = 1'b0; input_literals = '0; clause_valid = 1'b0;
        clause_class = '0; clause_polarity = 1'b0; clause_include = '0; clause_last = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_ready", clause_ready, 0);
        check("rst_pulses", {sum_valid, result_valid, clause_fire}, 0);
        check("rst_pred", {predicted_class, predicted_sum}, 0);
        reset = 1'b1;
        @(negedge clock);

        // Basic stream, x = A5
        start_run(8'hA5);
        check("s1_busy", busy, 1);
        check("s1_ready", clause_ready, 1);
        send(4'd0, 1'b1, 16'h0001, 1'b0, f); check("s1_fire0", f, 1);
        send(4'd0, 1'b0, 16'h0100, 1'b0, f); check("s1_fire1", f, 0);
        send(4'd0, 1'b1, 16'h0004, 1'b1, f); check("s1_fire2", f, 1);
        check("s1_no_early_sum", sum_valid, 0);
        @(negedge clock);
        check("s1_sum_valid", sum_valid, 1);
        check("s1_sum", {sum_class, sum_value}, {4'd0, 10'd2});
        check("s1_result_valid", result_valid, 1);
        check("s1_pred", {predicted_class, predicted_sum}, {4'd0, 10'd2});
        @(negedge clock);
        check("s1_idle", busy, 0);

        // Three classes -1/+3/+3, tie keeps class 1
        start_run(8'hA5);
        base = qc.size(); base_r = res_cnt;
        send(4'd0, 1'b0, 16'h0001, 1'b0, f);
        for (int i = 0; i < 3; i++) send(4'd1, 1'b1, 16'h0001, 1'b0, f);
        send(4'd2, 1'b1, 16'h0004, 1'b0, f);
        send(4'd2, 1'b1, 16'h0004, 1'b0, f);
        send(4'd2, 1'b1, 16'h0004, 1'b1, f);
        repeat (3) @(negedge clock);
        check("s2_nsums", qc.size() - base, 3);
        if (qc.size() - base == 3) begin
            check("s2_sum0", {qc[base], qv[base]}, {4'd0, 10'h3FF});
            check("s2_sum1", {qc[base+1], qv[base+1]}, {4'd1, 10'd3});
            check("s2_sum2", {qc[base+2], qv[base+2]}, {4'd2, 10'd3});
        end
        check("s2_nres", res_cnt - base_r, 1);
        check("s2_pred", {predicted_class, predicted_sum}, {4'd1, 10'd3});

        // Valid gaps, then a descriptor held through FLUSH/DONE
        start_run(8'hA5);
        base = qc.size();
        send(4'd0, 1'b1, 16'h0001, 1'b0, f); check("s3_fire0", f, 1);
        @(negedge clock);
        send(4'd0, 1'b0, 16'h0100, 1'b0, f); check("s3_fire1", f, 0);
        @(negedge clock);
        send(4'd0, 1'b1, 16'h0004, 1'b1, f); check("s3_fire2", f, 1);
        clause_class = 4'd7; clause_polarity = 1'b1; clause_include = 16'h0001; clause_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("s3_not_ready", clause_ready, 0);
            @(negedge clock);
        end
        clause_valid = 1'b0;
        @(negedge clock);
        check("s3_nsums", qc.size() - base, 1);
        if (qc.size() - base == 1) check("s3_sum", {qc[base], qv[base]}, {4'd0, 10'd2});
        check("s3_pred", {predicted_class, predicted_sum}, {4'd0, 10'd2});

        // Nine positive votes: SUM_W=4 instance saturates or wraps
        start_run(8'hA5);
        for (int i = 0; i < 9; i++) send(4'd3, 1'b1, 16'h0001, i == 8, f);
        @(negedge clock);
        check("s4_wide_sum", {sum_valid, sum_class, sum_value}, {1'b1, 4'd3, 10'd9});
        check("s4_narrow_valid", s4_sum_valid, 1);
`ifdef SUM_SATURATE_EN
        check("s4_narrow_sum", s4_sum_value, 4'h7);
        check("s4_narrow_pred", {s4_predicted_class, s4_predicted_sum}, {4'd3, 4'h7});
`else
        check("s4_narrow_sum", s4_sum_value, 4'h9);
        check("s4_narrow_pred", {s4_predicted_class, s4_predicted_sum}, {4'd3, 4'h9});
`endif
        @(negedge clock);

        // Last clause changes class; empty include never fires
        start_run(8'hA5);
        send(4'd4, 1'b1, 16'h0001, 1'b0, f);
        send(4'd4, 1'b1, 16'h0004, 1'b0, f);
        send(4'd5, 1'b1, 16'h0000, 1'b1, f);
        check("s5_empty_fire", f, 0);
        check("s5_sum4", {sum_valid, sum_class, sum_value}, {1'b1, 4'd4, 10'd2});
        check("s5_no_early_res", result_valid, 0);
        @(negedge clock);
        check("s5_sum5", {sum_valid, sum_class, sum_value}, {1'b1, 4'd5, 10'd0});
        check("s5_result_valid", result_valid, 1);
        check("s5_pred", {predicted_class, predicted_sum}, {4'd4, 10'd2});
        @(negedge clock);

        // Reset mid-run, then a clean run
        start_run(8'hA5);
        for (int i = 0; i < 3; i++) send(4'd0, 1'b1, 16'h0001, 1'b0, f);
        base = qc.size(); base_r = res_cnt;
        reset = 1'b0;
        #1;
        check("s6_busy", busy, 0);
        check("s6_ready", clause_ready, 0);
        check("s6_fire", clause_fire, 0);
        check("s6_pred", {predicted_class, predicted_sum}, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("s6_no_sum", qc.size() - base, 0);
        check("s6_no_res", res_cnt - base_r, 0);
        start_run(8'hA5);
        send(4'd0, 1'b1, 16'h0001, 1'b0, f);
        send(4'd0, 1'b0, 16'h0100, 1'b0, f);
        send(4'd0, 1'b1, 16'h0004, 1'b1, f);
        @(negedge clock);
        check("s6_rerun_sum", {sum_valid, sum_class, sum_value}, {1'b1, 4'd0, 10'd2});
        check("s6_rerun_pred", {result_valid, predicted_class, predicted_sum}, {1'b1, 4'd0, 10'd2});
        repeat (2) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
